// File: rtl/disaggregator.sv
// Splits wide FIFO words into narrow words, emitting the low W words of each.
// Ports: sender_* pops wide words (FWFT), receiver_* pushes narrow words,
// change_fetch_width/input_fetch_width request a new per-word width W.
module disaggregator #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 6,
  localparam int IW = $clog2(FETCH_WIDTH + 1),
  localparam int BW = FETCH_WIDTH * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BW-1:0]         sender_data,
  input  logic                  sender_empty_n,
  output logic                  sender_deq,
  output logic [DATA_WIDTH-1:0] receiver_data,
  input  logic                  receiver_full_n,
  output logic                  receiver_enq,
  input  logic                  change_fetch_width,
  input  logic [IW-1:0]         input_fetch_width
);

  localparam logic [IW-1:0] FW_MAX = IW'(FETCH_WIDTH);

  logic [BW-1:0]         wide_q, wide_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         w_q, w_d;
  logic [IW-1:0]         p_q, p_d;
  logic                  vld_q, vld_d;
  logic                  pend_q, pend_d;
  logic                  last;
  logic                  boundary;
  logic [IW-1:0]         req_w;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    word = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (idx_q == IW'(k)) begin
        word = wide_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign receiver_data = (vld_q && rst_n) ? word : '0;
  assign last          = (idx_q == w_q - 1'b1);
  assign receiver_enq  = vld_q & receiver_full_n & rst_n;
  // Boundary: no word held, or the last word of the held one leaves now.
  assign boundary      = !vld_q || (receiver_enq && last);
  assign sender_deq    = sender_empty_n & rst_n & boundary;

  assign req_w = (input_fetch_width == '0 || input_fetch_width > FW_MAX)
               ? FW_MAX : input_fetch_width;

  always_comb begin
    wide_d = wide_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    w_d    = w_q;
    p_d    = p_q;
    pend_d = pend_q;
    if (sender_deq) begin
      wide_d = sender_data;
      vld_d  = 1'b1;
      idx_d  = '0;
    end else if (receiver_enq) begin
      if (last) begin
        vld_d = 1'b0;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // Width switches only between words; a word loaded now uses w_d.
    if (boundary && pend_q) begin
      w_d    = p_q;
      pend_d = 1'b0;
    end
    // A request seen this cycle waits for the following boundary.
    if (change_fetch_width) begin
      p_d    = req_w;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wide_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      w_q    <= FW_MAX;
      p_q    <= FW_MAX;
      pend_q <= 1'b0;
    end else begin
      wide_q <= wide_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      w_q    <= w_d;
      p_q    <= p_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// Bench for disaggregator: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_disaggregator;

  localparam int DW = 8;
  localparam int FW = 6;
  localparam int IW = $clog2(FW + 1);
  localparam int BW = FW * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] sender_data = '0;
  logic          sender_empty_n = 1'b0;
  logic          sender_deq;
  logic [DW-1:0] receiver_data;
  logic          receiver_full_n = 1'b0;
  logic          receiver_enq;
  logic          change_fetch_width = 1'b0;
  logic [IW-1:0] input_fetch_width = '0;

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sender_data        (sender_data),
    .sender_empty_n     (sender_empty_n),
    .sender_deq         (sender_deq),
    .receiver_data      (receiver_data),
    .receiver_full_n    (receiver_full_n),
    .receiver_enq       (receiver_enq),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Environment FIFO (popped by DUT) and model's own copy of it.
  logic [BW-1:0] env_q[$];
  logic [BW-1:0] mod_q[$];
  // Narrow words still to be emitted from the current wide word.
  logic [DW-1:0] cur_q[$];
  int aw = FW;
  int pw = FW;
  bit pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [BW-1:0] w);
    env_q.push_back(w);
    mod_q.push_back(w);
  endtask

  task automatic step(input logic fn, input logic chg,
                      input logic [IW-1:0] fw, input logic rs);
    logic          e_enq, e_deq, bnd, d_deq;
    logic [DW-1:0] e_data;
    logic [BW-1:0] w;
    int            f;
    rst_n              = rs;
    receiver_full_n    = fn;
    change_fetch_width = chg;
    input_fetch_width  = fw;
    sender_empty_n     = env_q.size() > 0;
    sender_data        = sender_empty_n ? env_q[0] : '0;
    if (!rs) begin
      e_enq = 1'b0; e_deq = 1'b0; bnd = 1'b0; e_data = '0;
    end else begin
      e_enq  = cur_q.size() > 0 && fn;
      e_data = cur_q.size() > 0 ? cur_q[0] : '0;
      bnd    = cur_q.size() == 0 || (e_enq && cur_q.size() == 1);
      e_deq  = mod_q.size() > 0 && bnd;
    end
    @(negedge clk);
    chk("enq",  32'(receiver_enq),  32'(e_enq));
    chk("deq",  32'(sender_deq),    32'(e_deq));
    chk("data", 32'(receiver_data), 32'(e_data));
    d_deq = sender_deq;
    @(posedge clk);
    #1;
    if (d_deq && env_q.size() > 0) void'(env_q.pop_front());
    if (!rs) begin
      cur_q.delete();
      aw = FW;
      pend = 1'b0;
    end else begin
      if (e_enq) void'(cur_q.pop_front());
      if (bnd && pend) begin
        aw = pw;
        pend = 1'b0;
      end
      if (e_deq) begin
        w = mod_q.pop_front();
        for (int k = 0; k < aw; k++) cur_q.push_back(w[k*DW +: DW]);
      end
      if (chg) begin
        f = int'(fw);
        pw = (f == 0 || f > FW) ? FW : f;
        pend = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    #1;
    step(1'b1, 1'b1, 3'd2, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    // Two full-width words, bytes 0..11 in order.
    push(48'h050403020100);
    push(48'h0b0a09080706);
    run(14);
    // Width 2 requested while idle.
    step(1'b1, 1'b1, 3'd2, 1'b1);
    push(48'hAABBCCDD2120);
    push(48'h112233444140);
    run(6);
    // Back to 6, then request 4 mid-word.
    step(1'b1, 1'b1, 3'd6, 1'b1);
    run(2);
    push(48'h151413121110);
    push(48'h252423222120);
    push(48'h353433323130);
    run(3);
    step(1'b1, 1'b1, 3'd4, 1'b1);
    run(14);
    // Reset in the middle of a word.
    step(1'b1, 1'b1, 3'd6, 1'b1);
    run(2);
    push(48'h656463626160);
    push(48'h757473727170);
    run(4);
    step(1'b1, 1'b0, '0, 1'b0);
    run(10);
    // Out-of-range requests clamp to full width.
    step(1'b1, 1'b1, 3'd0, 1'b1);
    push(48'h868584838281);
    run(8);
    step(1'b1, 1'b1, 3'd7, 1'b1);
    push(48'h969594939291);
    run(8);
    // Width 1 streaming.
    step(1'b1, 1'b1, 3'd1, 1'b1);
    run(2);
    for (int i = 0; i < 5; i++) push(BW'({$urandom(), $urandom()}));
    run(8);
    // Random traffic with stalls, width changes and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (env_q.size() < 4 && $urandom_range(1, 0) == 1)
        push(BW'({$urandom(), $urandom()}));
      step($urandom_range(3, 0) != 0,
           $urandom_range(15, 0) == 0,
           IW'($urandom_range(7, 0)),
           $urandom_range(299, 0) != 0);
    end
    run(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/disaggregator.md
DISAGGREGATOR -- requirements
Module: disaggregator

Interface
REQ-001 Parameter DATA_WIDTH, default 8, narrow word width in bits.
REQ-002 Parameter FETCH_WIDTH, default 6, maximum narrow words per wide word.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word from upstream FIFO; valid whenever sender_empty_n is high (first-word-fall-through).
REQ-006 Port sender_empty_n  input  1  upstream FIFO holds at least one wide word.
REQ-007 Port sender_deq  output  1  pops upstream FIFO this cycle.
REQ-008 Port receiver_data  output  DATA_WIDTH  current narrow word.
REQ-009 Port receiver_full_n  input  1  downstream can accept a narrow word this cycle.
REQ-010 Port receiver_enq  output  1  pushes receiver_data downstream this cycle.
REQ-011 Port change_fetch_width  input  1  one-cycle request to load a new fetch width.
REQ-012 Port input_fetch_width  input  $clog2(FETCH_WIDTH+1)  requested words per wide word.

Function
REQ-013 Internal state: wide buffer, word index idx, buffer-valid flag, active width W, pending width P with pending flag.
REQ-014 Narrow word k of a wide word is bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]; words emitted k = 0, 1, ..., W-1 in order; words k >= W discarded.
REQ-015 receiver_data = buffer slice idx, combinational from registers; 0 when buffer invalid.
REQ-016 receiver_enq = valid AND receiver_full_n AND rst_n, combinational.
REQ-017 On receiver_enq with idx < W-1: idx increments next cycle; buffer unchanged.
REQ-018 On receiver_enq with idx = W-1 (last word): buffer becomes invalid, idx returns to 0, unless reloaded the same cycle (REQ-019).
REQ-019 sender_deq = sender_empty_n AND rst_n AND (NOT valid OR (receiver_enq AND idx = W-1)); no bubble between consecutive wide words, sustained throughput one narrow word per cycle.
REQ-020 On sender_deq, sender_data is captured into buffer, valid set, idx = 0.
REQ-021 receiver_full_n low: idx, buffer and valid hold; receiver_data stable.
REQ-022 change_fetch_width high: input_fetch_width captured into P, pending set; later request in the same or subsequent cycle overwrites P.
REQ-023 Pending width applied (W <= P, pending cleared) only at a wide-word boundary: buffer invalid, or last word emitted this cycle; the width in force when a wide word is loaded governs that whole word.
REQ-024 When change_fetch_width arrives in a boundary cycle, the new value takes effect on the next loaded wide word.
REQ-025 Requested width 0 or > FETCH_WIDTH clamps to FETCH_WIDTH.
REQ-026 W = 1: every accepted wide word produces one receiver_enq; deq and enq may coincide every cycle.

Reset
REQ-027 With rst_n low at a rising edge: valid = 0, idx = 0, buffer = 0, W = FETCH_WIDTH, pending cleared.
REQ-028 While rst_n low, sender_deq = 0, receiver_enq = 0, receiver_data = 0, regardless of other inputs.
REQ-029 Reset mid-word discards the remaining narrow words; no partial word emitted after release.
REQ-030 First sender_deq possible in the first cycle after rst_n returns high.

Verification
REQ-031 W=6, FIFO holds words with bytes {5,4,3,2,1,0} then {11..6}, receiver_full_n=1 -> receiver_data 0..11 on 12 consecutive cycles, sender_deq high on cycles 1 and 7 only.
REQ-032 change_fetch_width=1, input_fetch_width=2 while idle; wide word bytes {..,0x21,0x20} -> exactly two enqs, 0x20 then 0x21, then deq of next word.
REQ-033 W=6, change to 4 asserted while idx=2 -> current word finishes 6 enqs, next word emits 4, upper two bytes never appear.
REQ-034 receiver_full_n toggled randomly, counting upstream data -> output sequence gap-free and in order; receiver_data never changes while receiver_full_n low.
REQ-035 rst_n low for one cycle at idx=3 -> no enq during reset, idx=0, W=6 afterwards, next output is byte 0 of the next FIFO word.
REQ-036 input_fetch_width=0 and 7 requested -> both behave as W=6.
